// File: rtl/boot_pkg.sv
// Shared types and default widths for the boot loader and the blocks around it
// (BOOT_CONTROL, memory models).
package boot_pkg;

    localparam int BOOT_ADDR_WIDTH = 8;
    localparam int BOOT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        STABLE,
        READ,
        WAIT_ROM,
        WRITE,
        DONE
    } boot_state_t;

endpackage

// File: rtl/boot_loader_power_stable_filter.sv
// Counts consecutive power-good cycles and reports when power has been stable
// long enough; any low cycle restarts the count.
module power_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic is_powered_on,
    output logic stable
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at CNT_MAX so the level stays high for as long as power does.
    always_comb begin
        cnt_d = cnt_q;
        if (!is_powered_on) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/boot_loader.sv
// Copies the boot image from ROM to RAM after power settles, summing the words,
// then releases the CPU from reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH    = BOOT_ADDR_WIDTH,
    parameter int DATA_WIDTH    = BOOT_DATA_WIDTH,
    parameter int BOOT_WORDS    = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_powered_on,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_valid,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  ram_ready,
    output logic                  cpu_reset_n,
    output logic                  boot_done,
    output logic [DATA_WIDTH-1:0] checksum
);

    // Equality against the last index keeps BOOT_WORDS = 2**ADDR_WIDTH safe.
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BOOT_WORDS - 1);

    boot_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  rom_rd_q, rom_rd_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  cpu_reset_n_q, cpu_reset_n_d;
    logic                  boot_done_q, boot_done_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic                  stable;

    power_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_powered_on(is_powered_on),
        .stable       (stable)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        checksum_d = checksum_q;

        // Power loss outranks any same-cycle ROM data or RAM accept.
        if (state_q != IDLE && !is_powered_on) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_powered_on) begin
                        state_d    = STABLE;
                        idx_d      = '0;
                        rom_addr_d = '0;
                        ram_addr_d = '0;
                        checksum_d = '0;
                    end
                end
                STABLE: begin
                    if (stable) begin
                        state_d    = READ;
                        rom_addr_d = idx_q;
                    end
                end
                READ: state_d = WAIT_ROM;
                WAIT_ROM: begin
                    if (rom_valid) begin
                        state_d    = WRITE;
                        ram_data_d = rom_data;
                        ram_addr_d = idx_q;
                    end
                end
                WRITE: begin
                    if (ram_ready) begin
                        checksum_d = checksum_q + ram_data_q;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            state_d    = READ;
                            idx_d      = idx_q + 1'b1;
                            rom_addr_d = idx_q + 1'b1;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        rom_rd_d      = (state_d == READ);
        ram_we_d      = (state_d == WRITE);
        boot_done_d   = (state_d == DONE);
        cpu_reset_n_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rom_rd_q      <= 1'b0;
            rom_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            cpu_reset_n_q <= 1'b0;
            boot_done_q   <= 1'b0;
            checksum_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rom_rd_q      <= rom_rd_d;
            rom_addr_q    <= rom_addr_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            boot_done_q   <= boot_done_d;
            checksum_q    <= checksum_d;
        end
    end

    assign rom_rd      = rom_rd_q;
    assign rom_addr    = rom_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign boot_done   = boot_done_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a 4-word image with ROM/RAM models, plus a
// 2-word instance for checksum wrap and reset-in-DONE.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: BOOT_WORDS=4, STABLE_CYCLES=4
    logic       rst_n, pwr, rom_rd, ram_we, ram_ready, cpu_reset_n, boot_done;
    logic       rom_valid = 1'b0;
    logic [7:0] rom_addr, ram_addr, ram_data, checksum;
    logic [7:0] rom_data = 8'h00;

    // Instance 2: BOOT_WORDS=2, STABLE_CYCLES=4
    logic       rst2_n, pwr2, rom_rd2, ram_we2, cpu_reset_n2, boot_done2;
    logic       ram_ready2 = 1'b1;
    logic       rom_valid2 = 1'b0;
    logic [7:0] rom_addr2, ram_addr2, ram_data2, checksum2;
    logic [7:0] rom_data2 = 8'h00;

    boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BOOT_WORDS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .is_powered_on(pwr),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ready(ram_ready),
        .cpu_reset_n(cpu_reset_n), .boot_done(boot_done), .checksum(checksum)
    );

    boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BOOT_WORDS(2), .STABLE_CYCLES(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .is_powered_on(pwr2),
        .rom_rd(rom_rd2), .rom_addr(rom_addr2), .rom_valid(rom_valid2), .rom_data(rom_data2),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_ready(ram_ready2),
        .cpu_reset_n(cpu_reset_n2), .boot_done(boot_done2), .checksum(checksum2)
    );

    logic [7:0] rom_mem  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] rom_mem2 [2] = '{8'hFF, 8'h02};
    logic [7:0] ram_mem  [256];
    int         rom_lat = 1;
    int         rom_cnt = 0;
    logic [7:0] pend_addr = 8'h00;
    int         rd_count = 0;
    int         wr_count = 0;
    int         wr2_count = 0;
    logic       clr = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    // ROM model with programmable latency (cycles from the rom_rd edge to valid).
    always @(posedge clk) begin
        rom_valid <= 1'b0;
        if (clr) begin
            rd_count <= 0;
            rom_cnt  <= 0;
        end else begin
            if (rom_cnt == 1) begin
                rom_valid <= 1'b1;
                rom_data  <= rom_mem[pend_addr[1:0]];
            end
            if (rom_cnt > 0) rom_cnt <= rom_cnt - 1;
            if (rom_rd) begin
                rd_count  <= rd_count + 1;
                pend_addr <= rom_addr;
                if (rom_lat == 1) begin
                    rom_valid <= 1'b1;
                    rom_data  <= rom_mem[rom_addr[1:0]];
                end else begin
                    rom_cnt <= rom_lat - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (clr) begin
            wr_count  <= 0;
            wr2_count <= 0;
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
        end else if (ram_we && ram_ready) begin
            ram_mem[ram_addr] <= ram_data;
            wr_count <= wr_count + 1;
            if (ram_addr == 8'd2) wr2_count <= wr2_count + 1;
        end
    end

    always @(posedge clk) begin
        rom_valid2 <= rom_rd2;
        rom_data2  <= rom_mem2[rom_addr2[0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        pwr = 1'b0;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_done(output int cyc, input int limit);
        cyc = 0;
        while (!boot_done && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; pwr = 1'b0; ram_ready = 1'b1;
        rst2_n = 1'b0; pwr2 = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_rom_rd",      rom_rd,      0);
        check("rst_rom_addr",    rom_addr,    0);
        check("rst_ram_we",      ram_we,      0);
        check("rst_ram_addr",    ram_addr,    0);
        check("rst_ram_data",    ram_data,    0);
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_boot_done",   boot_done,   0);
        check("rst_checksum",    checksum,    0);
        clr = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic copy: done 4 + 12 + 1 cycles after power-up
        pwr = 1'b1;
        wait_done(n, 60);
        check("basic_done_latency", n, 17);
        check("basic_cpu_reset_n", cpu_reset_n, 1);
        check("basic_checksum", checksum, 8'hAA);
        check("basic_rd_count", rd_count, 4);
        check("basic_wr_count", wr_count, 4);
        check("basic_ram0", ram_mem[0], 8'h11);
        check("basic_ram1", ram_mem[1], 8'h22);
        check("basic_ram2", ram_mem[2], 8'h33);
        check("basic_ram3", ram_mem[3], 8'h44);
        repeat (3) tick();
        check("done_hold", boot_done, 1);
        check("done_no_rd", rom_rd, 0);
        check("done_checksum_frozen", checksum, 8'hAA);

        // Backpressure on word 2
        restart();
        pwr = 1'b1;
        n = 0;
        while (!(ram_we && ram_addr == 8'd2) && n < 60) begin
            tick();
            n++;
        end
        check("bp_reached_word2", n < 60, 1);
        ram_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) ram_ready = 1'b1;
            check("bp_ram_we",   ram_we,   1);
            check("bp_ram_addr", ram_addr, 8'd2);
            check("bp_ram_data", ram_data, 8'h33);
            if (c < 3) tick();
        end
        wait_done(n, 60);
        check("bp_done", boot_done, 1);
        check("bp_wr2_count", wr2_count, 1);
        check("bp_wr_count", wr_count, 4);
        check("bp_ram2", ram_mem[2], 8'h33);
        check("bp_checksum", checksum, 8'hAA);

        // Slow ROM: 5-cycle latency, 7 cycles per word
        restart();
        rom_lat = 5;
        pwr = 1'b1;
        wait_done(n, 100);
        check("slow_done_latency", n, 33);
        check("slow_rd_count", rd_count, 4);
        check("slow_ram2", ram_mem[2], 8'h33);
        check("slow_checksum", checksum, 8'hAA);
        rom_lat = 1;

        // Glitchy power: 3 high, 1 low, then needs 4 consecutive highs
        restart();
        pwr = 1'b1;
        repeat (3) tick();
        pwr = 1'b0;
        tick();
        pwr = 1'b1;
        check("glitch_no_rd", rd_count, 0);
        n = 0;
        while (!rom_rd && n < 20) begin
            tick();
            n++;
        end
        check("glitch_first_rd", n, 5);

        // Power loss in WRITE of word 1 with same-cycle ram_ready
        restart();
        pwr = 1'b1;
        n = 0;
        while (!(ram_we && ram_addr == 8'd1) && n < 60) begin
            tick();
            n++;
        end
        check("ploss_reached_word1", n < 60, 1);
        pwr = 1'b0;
        tick();
        check("ploss_ram_we", ram_we, 0);
        check("ploss_boot_done", boot_done, 0);
        check("ploss_cpu_reset_n", cpu_reset_n, 0);
        check("ploss_checksum", checksum, 8'h11);
        restart();
        check("ploss_checksum_kept", checksum, 8'h11);
        pwr = 1'b1;
        wait_done(n, 60);
        check("recopy_latency", n, 17);
        check("recopy_checksum", checksum, 8'hAA);

        // Checksum wrap on the 2-word instance, then reset in DONE
        rst2_n = 1'b1;
        tick();
        pwr2 = 1'b1;
        n = 0;
        while (!boot_done2 && n < 40) begin
            tick();
            n++;
        end
        check("wrap_done_latency", n, 11);
        check("wrap_checksum", checksum2, 8'h01);
        check("wrap_cpu_reset_n", cpu_reset_n2, 1);
        rst2_n = 1'b0;
        tick();
        check("rst_done_rom_rd",      rom_rd2,      0);
        check("rst_done_rom_addr",    rom_addr2,    0);
        check("rst_done_ram_we",      ram_we2,      0);
        check("rst_done_ram_addr",    ram_addr2,    0);
        check("rst_done_ram_data",    ram_data2,    0);
        check("rst_done_cpu_reset_n", cpu_reset_n2, 0);
        check("rst_done_boot_done",   boot_done2,   0);
        check("rst_done_checksum",    checksum2,    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
